// File: rtl/i2s_receiver.sv
// I2S stereo receiver: 16-bit MSB-first words captured on rising bitclk,
// paired left/right and presented on a valid/ready output with sticky error flags.
module i2s_receiver (
  input  logic        bitclk,
  input  logic        nReset,
  input  logic        dataIn,
  input  logic        wordSelect,
  input  logic        sampleReady,
  input  logic        clearErrors,
  output logic [15:0] leftSample,
  output logic [15:0] rightSample,
  output logic        sampleValid,
  output logic        overrun,
  output logic        shortWord
);

  typedef enum logic {SYNC, RECEIVE} state_t;

  state_t      state, state_next;
  logic        ws_prev, ws_prev_next;
  logic        channel, channel_next;
  logic [4:0]  bit_count, bit_count_next;
  logic [14:0] shift, shift_next;
  logic [15:0] left_hold, left_hold_next;
  logic        left_hold_valid, left_hold_valid_next;
  logic [15:0] left_sample_next, right_sample_next;
  logic        sample_valid_next, overrun_next, short_word_next;

  logic        ws_change;
  logic        word_done;
  logic [15:0] word;
  logic        pair;
  logic        short_set;
  logic        overrun_set;

  assign ws_change = (wordSelect != ws_prev);
  assign word      = {shift, dataIn};
  assign word_done = (state == RECEIVE) && (bit_count == 5'd15);

  always_comb begin
    state_next           = state;
    ws_prev_next         = wordSelect;
    channel_next         = channel;
    bit_count_next       = bit_count;
    shift_next           = shift;
    left_hold_next       = left_hold;
    left_hold_valid_next = left_hold_valid;
    left_sample_next     = leftSample;
    right_sample_next    = rightSample;
    sample_valid_next    = sampleValid;
    pair                 = 1'b0;
    short_set            = 1'b0;
    overrun_set          = 1'b0;

    case (state)
      SYNC: begin
        if (ws_change) begin
          state_next     = RECEIVE;
          bit_count_next = 5'd0;
          channel_next   = wordSelect;
        end
      end
      RECEIVE: begin
        // bit_count saturates at 16 so bits past a 16-bit word are dropped
        if (bit_count < 5'd16) begin
          shift_next     = {shift[13:0], dataIn};
          bit_count_next = bit_count + 5'd1;
        end
        if (word_done) begin
          if (!channel) begin
            left_hold_next       = word;
            left_hold_valid_next = 1'b1;
          end else if (left_hold_valid) begin
            pair                 = 1'b1;
            left_hold_valid_next = 1'b0;
          end
        end
        // A slot boundary always restarts capture, even on the word-complete edge
        if (ws_change) begin
          bit_count_next = 5'd0;
          channel_next   = wordSelect;
          if (bit_count < 5'd15) begin
            short_set            = 1'b1;
            left_hold_valid_next = 1'b0;
          end
        end
      end
    endcase

    if (pair) begin
      if (!sampleValid || sampleReady) begin
        left_sample_next  = left_hold;
        right_sample_next = word;
        sample_valid_next = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (sampleValid && sampleReady) begin
      sample_valid_next = 1'b0;
    end

    overrun_next    = overrun_set | (overrun & ~clearErrors);
    short_word_next = short_set | (shortWord & ~clearErrors);
  end

  always_ff @(posedge bitclk) begin
    if (!nReset) begin
      state           <= SYNC;
      ws_prev         <= 1'b0;
      channel         <= 1'b0;
      bit_count       <= 5'd0;
      shift           <= 15'd0;
      left_hold       <= 16'd0;
      left_hold_valid <= 1'b0;
      leftSample      <= 16'd0;
      rightSample     <= 16'd0;
      sampleValid     <= 1'b0;
      overrun         <= 1'b0;
      shortWord       <= 1'b0;
    end else begin
      state           <= state_next;
      ws_prev         <= ws_prev_next;
      channel         <= channel_next;
      bit_count       <= bit_count_next;
      shift           <= shift_next;
      left_hold       <= left_hold_next;
      left_hold_valid <= left_hold_valid_next;
      leftSample      <= left_sample_next;
      rightSample     <= right_sample_next;
      sampleValid     <= sample_valid_next;
      overrun         <= overrun_next;
      shortWord       <= short_word_next;
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: streams are built as lists of I2S slots; expected pair and
// short-slot events are derived per slot, then the output handshake is modelled per edge.
module tb_i2s_receiver;

  logic        bitclk = 1'b0;
  logic        nReset = 1'b0;
  logic        dataIn = 1'b0;
  logic        wordSelect = 1'b0;
  logic        sampleReady = 1'b0;
  logic        clearErrors = 1'b0;
  logic [15:0] leftSample;
  logic [15:0] rightSample;
  logic        sampleValid;
  logic        overrun;
  logic        shortWord;

  i2s_receiver dut (
    .bitclk      (bitclk),
    .nReset      (nReset),
    .dataIn      (dataIn),
    .wordSelect  (wordSelect),
    .sampleReady (sampleReady),
    .clearErrors (clearErrors),
    .leftSample  (leftSample),
    .rightSample (rightSample),
    .sampleValid (sampleValid),
    .overrun     (overrun),
    .shortWord   (shortWord)
  );

  always #5 bitclk = ~bitclk;

  localparam int MAXS = 16;
  localparam int MAXE = 1024;

  int checks = 0;
  int errors = 0;

  // slot list of the current stream
  int          n_slots;
  bit          s_ws   [MAXS];
  int          s_len  [MAXS];
  logic [15:0] s_word [MAXS];
  bit          s_fill1[MAXS];

  // per-edge stimulus and expected events
  bit          ws_a    [MAXE];
  bit          d_a     [MAXE];
  bit          ev_pair [MAXE];
  bit          ev_short[MAXE];
  logic [15:0] ev_l    [MAXE];
  logic [15:0] ev_r    [MAXE];

  // expected output state
  logic [15:0] m_l, m_r;
  bit          m_v, m_ov, m_sw;

  task automatic check_val(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic new_stream();
    n_slots = 0;
  endtask

  task automatic add_slot(bit ws, int len, logic [15:0] word, bit fill1);
    s_ws[n_slots]    = ws;
    s_len[n_slots]   = len;
    s_word[n_slots]  = word;
    s_fill1[n_slots] = fill1;
    n_slots++;
  endtask

  task automatic model_step(bit rst_n, bit ready, bit clr, int e);
    bit ov_set;
    ov_set = 1'b0;
    if (!rst_n) begin
      m_l = 16'd0; m_r = 16'd0; m_v = 1'b0; m_ov = 1'b0; m_sw = 1'b0;
    end else begin
      if (ev_pair[e]) begin
        if (!m_v || ready) begin
          m_l = ev_l[e]; m_r = ev_r[e]; m_v = 1'b1;
        end else begin
          ov_set = 1'b1;
        end
      end else if (m_v && ready) begin
        m_v = 1'b0;
      end
      m_ov = ov_set | (m_ov & !clr);
      m_sw = ev_short[e] | (m_sw & !clr);
    end
  endtask

  task automatic compare_outputs(string name, int e);
    string pre;
    pre = $sformatf("%s@%0d", name, e);
    check_val({pre, ".leftSample"},  leftSample,  m_l);
    check_val({pre, ".rightSample"}, rightSample, m_r);
    check_val({pre, ".sampleValid"}, {15'd0, sampleValid}, {15'd0, m_v});
    check_val({pre, ".overrun"},     {15'd0, overrun},     {15'd0, m_ov});
    check_val({pre, ".shortWord"},   {15'd0, shortWord},   {15'd0, m_sw});
  endtask

  // ready_mode: 0 low, 1 high, 2 random. clr_mode: 0 none, 1 random, 2 pulse on last edge.
  // trunc > 0 cuts the stream short; the next scenario then resets mid-word.
  task automatic run_scenario(string name, int ready_mode, int clr_mode, int trunc);
    int          t;
    int          n_edges;
    int          e;
    bit          prev_ws;
    bit          synced;
    bit          hv;
    logic [15:0] hold;
    bit          b;
    bit          rdy;
    bit          clr;

    for (int i = 0; i < MAXE; i++) begin
      ws_a[i] = 1'b0; d_a[i] = 1'($urandom_range(0, 1));
      ev_pair[i] = 1'b0; ev_short[i] = 1'b0; ev_l[i] = 16'd0; ev_r[i] = 16'd0;
    end

    // The receiver locks on at the first word-select change after reset (which
    // starts from 0); from there every slot is a captured slot.
    t = 0; prev_ws = 1'b0; synced = 1'b0; hv = 1'b0; hold = 16'd0;
    for (int s = 0; s < n_slots; s++) begin
      for (int k = 0; k < s_len[s]; k++) begin
        ws_a[t + k] = s_ws[s];
        if (k < 16) b = s_word[s][15 - k];
        else        b = s_fill1[s] ? 1'b1 : 1'($urandom_range(0, 1));
        if (t + k + 1 < MAXE) d_a[t + k + 1] = b;
      end
      if (s_ws[s] != prev_ws) synced = 1'b1;
      if (synced) begin
        if (s_len[s] >= 16) begin
          e = t + 16;
          if (s_ws[s] == 1'b0) begin
            hold = s_word[s]; hv = 1'b1;
          end else if (hv) begin
            if (e < MAXE) begin
              ev_pair[e] = 1'b1; ev_l[e] = hold; ev_r[e] = s_word[s];
            end
            hv = 1'b0;
          end
        end else if (s < n_slots - 1) begin
          ev_short[t + s_len[s]] = 1'b1;
          hv = 1'b0;
        end
      end
      prev_ws = s_ws[s];
      t += s_len[s];
    end
    n_edges = t;
    if (trunc > 0 && trunc < n_edges) n_edges = trunc;

    for (int r = 0; r < 2; r++) begin
      @(negedge bitclk);
      nReset      = 1'b0;
      wordSelect  = 1'($urandom_range(0, 1));
      dataIn      = 1'($urandom_range(0, 1));
      sampleReady = 1'($urandom_range(0, 1));
      clearErrors = 1'b0;
      @(posedge bitclk);
      #1;
      model_step(1'b0, 1'b0, 1'b0, 0);
      compare_outputs({name, ".reset"}, r);
    end

    for (int i = 0; i < n_edges; i++) begin
      case (ready_mode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      case (clr_mode)
        1:       clr = ($urandom_range(0, 15) == 0);
        2:       clr = (i == n_edges - 1);
        default: clr = 1'b0;
      endcase
      @(negedge bitclk);
      nReset      = 1'b1;
      wordSelect  = ws_a[i];
      dataIn      = d_a[i];
      sampleReady = rdy;
      clearErrors = clr;
      @(posedge bitclk);
      #1;
      model_step(1'b1, rdy, clr, i);
      compare_outputs(name, i);
    end
    $display("scenario %s: %0d edges, %0d checks so far, %0d errors so far",
             name, n_edges, checks, errors);
  endtask

  initial begin
    m_l = 16'd0; m_r = 16'd0; m_v = 1'b0; m_ov = 1'b0; m_sw = 1'b0;

    // Sync on a right slot, then a 16-bit frame L=A5C3 R=1234
    new_stream();
    add_slot(1'b0, 3, 16'h0000, 1'b0);
    add_slot(1'b1, 16, 16'h5A5A, 1'b0);
    add_slot(1'b0, 16, 16'hA5C3, 1'b0);
    add_slot(1'b1, 16, 16'h1234, 1'b0);
    add_slot(1'b0, 16, 16'h0F0F, 1'b0);
    run_scenario("frame16", 1, 0, 0);

    // 32-bit slots with trailing ones
    new_stream();
    add_slot(1'b0, 2, 16'h0000, 1'b1);
    add_slot(1'b1, 32, 16'hFFFF, 1'b1);
    add_slot(1'b0, 32, 16'h8001, 1'b1);
    add_slot(1'b1, 32, 16'h7FFE, 1'b1);
    add_slot(1'b0, 20, 16'h1111, 1'b1);
    run_scenario("slot32", 1, 0, 0);

    // Consumer stalled: first pair held, later pairs dropped, then cleared
    new_stream();
    add_slot(1'b0, 2, 16'h0000, 1'b0);
    add_slot(1'b1, 16, 16'h0000, 1'b0);
    add_slot(1'b0, 16, 16'h1357, 1'b0);
    add_slot(1'b1, 16, 16'h2468, 1'b0);
    add_slot(1'b0, 16, 16'hDEAD, 1'b0);
    add_slot(1'b1, 16, 16'hBEEF, 1'b0);
    add_slot(1'b0, 16, 16'h0000, 1'b0);
    run_scenario("overrun", 0, 2, 0);

    // Short left slot, right discarded, next frame delivered
    new_stream();
    add_slot(1'b0, 2, 16'h0000, 1'b0);
    add_slot(1'b1, 16, 16'hCAFE, 1'b0);
    add_slot(1'b0, 10, 16'hFFFF, 1'b0);
    add_slot(1'b1, 16, 16'hABCD, 1'b0);
    add_slot(1'b0, 16, 16'h4321, 1'b0);
    add_slot(1'b1, 16, 16'h8765, 1'b0);
    add_slot(1'b0, 16, 16'h0000, 1'b0);
    run_scenario("short", 1, 0, 0);

    // Capture begins on a right slot right after reset
    new_stream();
    add_slot(1'b1, 16, 16'h9999, 1'b0);
    add_slot(1'b0, 16, 16'h0102, 1'b0);
    add_slot(1'b1, 16, 16'h0304, 1'b0);
    add_slot(1'b0, 5, 16'h0000, 1'b0);
    run_scenario("right_first", 1, 0, 0);

    // Pair held, then the stream is cut mid right word; next scenario resets
    new_stream();
    add_slot(1'b0, 2, 16'h0000, 1'b0);
    add_slot(1'b1, 16, 16'h0000, 1'b0);
    add_slot(1'b0, 16, 16'h7777, 1'b0);
    add_slot(1'b1, 16, 16'h8888, 1'b0);
    add_slot(1'b0, 16, 16'h3C3C, 1'b0);
    add_slot(1'b1, 16, 16'hC3C3, 1'b0);
    run_scenario("reset_cut", 0, 0, 2 + 16 * 4 + 8);

    for (int r = 0; r < 8; r++) begin
      int nsl;
      int len;
      bit ws;
      new_stream();
      ws = 1'($urandom_range(0, 1));
      add_slot(ws, $urandom_range(1, 5), 16'($urandom), 1'b0);
      nsl = $urandom_range(6, 10);
      for (int s = 0; s < nsl; s++) begin
        ws = ~ws;
        if ($urandom_range(0, 9) < 7) len = 16;
        else                          len = $urandom_range(8, 34);
        add_slot(ws, len, 16'($urandom), 1'($urandom_range(0, 1)));
      end
      run_scenario($sformatf("random%0d", r), 2, 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
